// File: rtl/nn_pkg.sv
// nn_pkg: constants, driver state encoding and result record shared by the
// frame driver and the sparse-network classifier.
package nn_pkg;

  // Layer-0 size of the classifier and its signed word width.
  localparam int unsigned FEAT_LEN = 420;
  localparam int unsigned DATA_W   = 32;

  // Frame driver states.
  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_PRIME = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CAP1  = 3'd4,
    ST_OUT   = 3'd5
  } drv_state_e;

  // Classification record presented downstream.
  typedef struct packed {
    logic signed [DATA_W-1:0] score0;
    logic signed [DATA_W-1:0] score1;
    logic                     cls;
    logic                     timeout;
  } nn_result_t;

endpackage

// File: rtl/feat_buf.sv
// feat_buf: single-port synchronous RAM holding one feature frame.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears read port only)
//   we, addr, wdata - write port (shares addr with the read port)
//   rd_en           - read enable; when low the read register is cleared to 0
//   rdata           - read data, one cycle after addr/rd_en
module feat_buf #(
  parameter int unsigned DEPTH = 420,
  parameter int unsigned W     = 32,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage array; no reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register is zeroed when not reading so the load port sees 0 off-burst.
  always_ff @(posedge clk) begin
    if (reset)      rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[addr];
    else            rdata_q <= '0;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nn_frame_driver.sv
// nn_frame_driver: buffers one feature frame from a valid/ready stream, bursts
// it into the classifier load port, captures the two scores and presents a
// classification record downstream.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   in_valid/in_data/in_ready     - feature stream in
//   nn_start/nn_write/nn_x        - classifier start, write, x_i
//   nn_dv/nn_x_o                  - classifier dv, x_o
//   res_valid/res_ready           - result handshake
//   res_score0/res_score1/res_class/res_timeout - result record
//   busy                          - high in every state but LOAD
module nn_frame_driver
  import nn_pkg::*;
#(
  parameter int unsigned FEAT_LEN = nn_pkg::FEAT_LEN,
  parameter int unsigned DATA_W   = nn_pkg::DATA_W,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              nn_start,
  output logic              nn_write,
  output logic [DATA_W-1:0] nn_x,
  input  logic              nn_dv,
  input  logic [DATA_W-1:0] nn_x_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_score0,
  output logic [DATA_W-1:0] res_score1,
  output logic              res_class,
  output logic              res_timeout,
  output logic              busy
);

  localparam int unsigned AW      = (FEAT_LEN > 1) ? $clog2(FEAT_LEN) : 1;
  localparam int unsigned TW      = $clog2(TIMEOUT + 1);
  localparam int unsigned SCORE_W = nn_pkg::DATA_W;

  drv_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  nn_result_t  rec_q, rec_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        nn_start_q, nn_start_d;
  logic        nn_write_q, nn_write_d;
  logic        res_valid_q, res_valid_d;

  logic          buf_we;
  logic          buf_rd_en;
  logic [AW-1:0] buf_addr;
  logic [DATA_W-1:0] buf_rdata;

  // Frame buffer; its read register drives nn_x directly.
  feat_buf #(
    .DEPTH (FEAT_LEN),
    .W     (DATA_W),
    .AW    (AW)
  ) u_feat_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .rd_en (buf_rd_en),
    .addr  (buf_addr),
    .wdata (in_data),
    .rdata (buf_rdata)
  );

  // Next-state, counters, buffer control and capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rec_d    = rec_q;
    buf_we   = 1'b0;
    buf_addr = cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          buf_we = 1'b1;
          if (cnt_q == AW'(FEAT_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_PRIME;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_PRIME: begin
        buf_addr = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        // Address runs one word ahead of the word on nn_x.
        if (cnt_q == AW'(FEAT_LEN - 1)) begin
          buf_addr = '0;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = ST_WAIT;
        end else begin
          buf_addr = cnt_q + AW'(1);
          cnt_d    = cnt_q + AW'(1);
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (nn_dv) begin
          rec_d.score0 = SCORE_W'(nn_x_o);
          state_d      = ST_CAP1;
        end else if (tmo_d == TW'(TIMEOUT)) begin
          rec_d         = '0;
          rec_d.timeout = 1'b1;
          state_d       = ST_OUT;
        end
      end
      ST_CAP1: begin
        // Class is decided locally; the classifier's own flag is sticky.
        rec_d.score1  = SCORE_W'(nn_x_o);
        rec_d.cls     = ($signed(rec_q.score0) > $signed(SCORE_W'(nn_x_o)));
        rec_d.timeout = 1'b0;
        state_d       = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          rec_d.timeout = 1'b0;
          state_d       = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    buf_rd_en   = (state_d == ST_SEND);
    in_ready_d  = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_LOAD);
    nn_start_d  = (state_d == ST_PRIME) || (state_d == ST_SEND) ||
                  (state_d == ST_WAIT)  || (state_d == ST_CAP1);
    nn_write_d  = (state_d == ST_SEND);
    res_valid_d = (state_d == ST_OUT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rec_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      nn_start_q  <= 1'b0;
      nn_write_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rec_q       <= rec_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      nn_start_q  <= nn_start_d;
      nn_write_q  <= nn_write_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign nn_start    = nn_start_q;
  assign nn_write    = nn_write_q;
  assign nn_x        = buf_rdata;
  assign res_valid   = res_valid_q;
  assign res_score0  = DATA_W'(rec_q.score0);
  assign res_score1  = DATA_W'(rec_q.score1);
  assign res_class   = rec_q.cls;
  assign res_timeout = rec_q.timeout;

endmodule
